// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU word, popcount width and status-flag types
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_CNT_W = $clog2(ALU_WIDTH + 1);

  typedef logic [ALU_WIDTH-1:0] alu_word_t;

  // popcnt is one bit wider than log2(WIDTH) so a full word (8) fits
  typedef struct packed {
    logic                 zero;
    logic                 ones;
    logic                 parity;
    logic [ALU_CNT_W-1:0] popcnt;
  } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational status flags for one ALU result word
module alu_flag_gen
  import alu_pkg::*;
(
  input  alu_word_t  word,
  output alu_flags_t flags
);

  // level 1: four 2-bit sums of adjacent bit pairs
  logic [1:0] sum_l1 [4];
  // level 2: two 3-bit sums of adjacent pairs
  logic [2:0] sum_l2 [2];

  for (genvar i = 0; i < 4; i++) begin : g_l1
    assign sum_l1[i] = {1'b0, word[2*i]} + {1'b0, word[2*i+1]};
  end

  for (genvar j = 0; j < 2; j++) begin : g_l2
    assign sum_l2[j] = {1'b0, sum_l1[2*j]} + {1'b0, sum_l1[2*j+1]};
  end

  // Final adder of the tree plus the reduction flags
  always_comb begin
    flags        = '0;
    flags.popcnt = {1'b0, sum_l2[0]} + {1'b0, sum_l2[1]};
    flags.zero   = ~|word;
    flags.ones   = &word;
    flags.parity = ^word;
  end

endmodule

// File: rtl/or_8_bit.sv
// rtl/or_8_bit.sv - bitwise-OR ALU slice with registered result and flags
module or_8_bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             ones_q,
  output logic             parity_q,
  output logic [CNT_W-1:0] popcnt_q
);

  alu_flags_t flags;

  // The OR array itself: never registered or gated
  assign Y = A | B;

  // Flags are taken from the OR result only, never from A or B
  alu_flag_gen u_flag_gen (
    .word  (Y),
    .flags (flags)
  );

  // Output stage: capture on in_valid, otherwise hold data and drop valid
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      ones_q    <= 1'b0;
      parity_q  <= 1'b0;
      popcnt_q  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q      <= Y;
        zero_q   <= flags.zero;
        ones_q   <= flags.ones;
        parity_q <= flags.parity;
        popcnt_q <= flags.popcnt;
      end
    end
  end

endmodule

// File: tb/tb_or_8_bit.sv
// tb/tb_or_8_bit.sv - directed and randomised self-checking bench for or_8_bit
module tb_or_8_bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       out_valid;
  logic       zero_q;
  logic       ones_q;
  logic       parity_q;
  logic [3:0] popcnt_q;

  int vectors;
  int miscompares;

  or_8_bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .in_valid  (in_valid),
    .Y         (y),
    .y_q       (y_q),
    .out_valid (out_valid),
    .zero_q    (zero_q),
    .ones_q    (ones_q),
    .parity_q  (parity_q),
    .popcnt_q  (popcnt_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_comb();
    logic [7:0] ta [4] = '{8'b0000_0000, 8'b1111_0000, 8'b0000_1111, 8'b0101_0101};
    logic [7:0] tb [4] = '{8'b0000_0000, 8'b1010_1010, 8'b1111_0000, 8'b1010_1010};
    logic [7:0] ty [4] = '{8'b0000_0000, 8'b1111_1010, 8'b1111_1111, 8'b1111_1111};
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = ta[i];
      b = tb[i];
      #10;
      vectors++;
      if (y !== ty[i]) begin
        miscompares++;
        $display("FAIL comb_y[%0d]: got %h expected %h", i, y, ty[i]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({y_q, out_valid, zero_q, ones_q, parity_q, popcnt_q} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got y_q=%h v=%b z=%b o=%b p=%b c=%0d expected all 0",
               y_q, out_valid, zero_q, ones_q, parity_q, popcnt_q);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (y_q !== 8'hFF || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got y_q=%h v=%b expected ff/1", y_q, out_valid);
    end
  endtask

  task automatic test_registered();
    a = 8'hF0;
    b = 8'hAA;
    in_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (y_q !== 8'hFA || out_valid !== 1'b1 || zero_q !== 1'b0 || ones_q !== 1'b0 ||
        popcnt_q !== 4'd6 || parity_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_capture: got y_q=%h v=%b z=%b o=%b p=%b c=%0d expected fa/1/0/0/0/6",
               y_q, out_valid, zero_q, ones_q, parity_q, popcnt_q);
    end
    a = 8'h00;
    b = 8'h00;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || y_q !== 8'hFA || popcnt_q !== 4'd6 || zero_q !== 1'b0) begin
      miscompares++;
      $display("FAIL reg_hold: got y_q=%h v=%b z=%b c=%0d expected fa/0/0/6",
               y_q, out_valid, zero_q, popcnt_q);
    end
  endtask

  task automatic test_flags();
    logic [7:0] fa [3] = '{8'h00, 8'h0F, 8'h01};
    logic [7:0] fb [3] = '{8'h00, 8'hF0, 8'h00};
    logic [7:0] fy [3] = '{8'h00, 8'hFF, 8'h01};
    logic       fz [3] = '{1'b1, 1'b0, 1'b0};
    logic       fo [3] = '{1'b0, 1'b1, 1'b0};
    logic       fp [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] fc [3] = '{4'd0, 4'd8, 4'd1};
    for (int i = 0; i < 3; i++) begin
      a = fa[i];
      b = fb[i];
      in_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (y_q !== fy[i] || zero_q !== fz[i] || ones_q !== fo[i] ||
          parity_q !== fp[i] || popcnt_q !== fc[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL flags[%0d]: got y_q=%h z=%b o=%b p=%b c=%0d v=%b expected %h/%b/%b/%b/%0d/1",
                 i, y_q, zero_q, ones_q, parity_q, popcnt_q, out_valid,
                 fy[i], fz[i], fo[i], fp[i], fc[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ba [4] = '{8'h11, 8'h40, 8'h80, 8'h0F};
    logic [7:0] bb [4] = '{8'h22, 8'h04, 8'h01, 8'h00};
    logic [7:0] by [4] = '{8'h33, 8'h44, 8'h81, 8'h0F};
    logic [3:0] bc [4] = '{4'd4, 4'd2, 4'd2, 4'd4};
    for (int i = 0; i < 4; i++) begin
      a = ba[i];
      b = bb[i];
      in_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (y_q !== by[i] || out_valid !== 1'b1 || popcnt_q !== bc[i]) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got y_q=%h v=%b c=%0d expected %h/1/%0d",
                 i, y_q, out_valid, popcnt_q, by[i], bc[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      a = ba[i];
      b = bb[i];
      in_valid = 1'b1;
      rst = (i == 2);
      @(negedge clk);
      vectors++;
      if (i == 2) begin
        if (y_q !== 8'h00 || out_valid !== 1'b0 || popcnt_q !== 4'd0 || zero_q !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_rst: got y_q=%h v=%b c=%0d z=%b expected 00/0/0/0",
                   y_q, out_valid, popcnt_q, zero_q);
        end
      end else if (y_q !== by[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_rst_seq[%0d]: got y_q=%h v=%b expected %h/1",
                 i, y_q, out_valid, by[i]);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0]  exp_y;
    logic        exp_v;
    logic [3:0]  exp_c;
    logic [31:0] r;
    int          n;
    exp_y = y_q;
    exp_c = popcnt_q;
    exp_v = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      r = $urandom;
      a = r[7:0];
      b = r[15:8];
      in_valid = r[16];
      #1;
      vectors++;
      if (y !== (r[7:0] | r[15:8])) begin
        miscompares++;
        $display("FAIL rand_y[%0d]: got %h expected %h", k, y, r[7:0] | r[15:8]);
      end
      if (r[16]) begin
        exp_y = r[7:0] | r[15:8];
        n = 0;
        for (int bit_i = 0; bit_i < 8; bit_i++) n += int'(exp_y[bit_i]);
        exp_c = n[3:0];
      end
      exp_v = r[16];
      @(negedge clk);
      vectors++;
      if (y_q !== exp_y || out_valid !== exp_v || popcnt_q !== exp_c ||
          parity_q !== exp_c[0] || zero_q !== (exp_c == 4'd0) || ones_q !== (exp_c == 4'd8)) begin
        miscompares++;
        $display("FAIL rand_reg[%0d]: got y_q=%h v=%b c=%0d p=%b z=%b o=%b expected %h/%b/%0d",
                 k, y_q, out_valid, popcnt_q, parity_q, zero_q, ones_q, exp_y, exp_v, exp_c);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    test_comb();
    test_reset();
    test_registered();
    test_flags();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
